// File: rtl/pd_mem_checker.sv
// rtl/pd_mem_checker.sv - RAM fill/verify engine: CSR slave plus a 32-bit RAM master port
module pd_mem_checker #(
  parameter int          DEPTH   = 25024,
  parameter int          ADDR_W  = 15,
  parameter logic [15:0] ERR_MAX = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic [31:0]       m_readdata,
  output logic              irq
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] RDISS  = 2'd2;
  localparam logic [1:0] RDLAST = 2'd3;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q;
  logic              done_q;
  logic              irq_en_q;
  logic              verify_q;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       len_q;
  logic [31:0]       seed_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [15:0]       err_cnt_q;
  logic [ADDR_W-1:0] start_addr_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [31:0]       cur_data_q;
  logic [15:0]       cnt_q;
  logic              exp_valid_q;
  logic [31:0]       exp_data_q;
  logic [ADDR_W-1:0] exp_addr_q;

  logic              busy;
  logic              ctrl_wr;
  logic              start;
  logic              rd_mismatch;
  logic [ADDR_W-1:0] start_base;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       rd_mux;

  assign busy        = (state_q != IDLE);
  assign ctrl_wr     = csr_write && (csr_address == 3'd0);
  assign start       = ctrl_wr && csr_writedata[0] && !busy;
  assign rd_mismatch = exp_valid_q && (m_readdata != exp_data_q);

  // BASE is at most 2^ADDR_W-1 < 2*DEPTH, so a single subtraction reduces it.
  assign start_base = (base_q >= DEPTH_A) ? (base_q - DEPTH_A) : base_q;
  assign next_addr  = (cur_addr_q == LAST_A) ? '0 : (cur_addr_q + ADDR_W'(1));

  assign m_write      = (state_q == FILL);
  assign m_chipselect = m_write;
  assign m_address    = cur_addr_q;
  assign m_writedata  = cur_data_q;
  assign m_byteenable = 4'hF;
  assign irq          = done_q && irq_en_q;

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      3'd0:    rd_mux = {28'd0, verify_q, irq_en_q, done_q, busy};
      3'd1:    rd_mux = 32'(base_q);
      3'd2:    rd_mux = {16'd0, len_q};
      3'd3:    rd_mux = seed_q;
      3'd4:    rd_mux = 32'(fail_addr_q);
      3'd5:    rd_mux = {16'd0, err_cnt_q};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      verify_q     <= 1'b0;
      base_q       <= '0;
      len_q        <= '0;
      seed_q       <= '0;
      fail_addr_q  <= '0;
      err_cnt_q    <= '0;
      start_addr_q <= '0;
      cur_addr_q   <= '0;
      cur_data_q   <= '0;
      cnt_q        <= '0;
      exp_valid_q  <= 1'b0;
      exp_data_q   <= '0;
      exp_addr_q   <= '0;
      csr_readdata <= '0;
    end else begin
      csr_readdata <= csr_read ? rd_mux : '0;
      exp_valid_q  <= 1'b0;

      if (csr_write && !busy) begin
        case (csr_address)
          3'd1:    base_q <= csr_writedata[ADDR_W-1:0];
          3'd2:    len_q  <= csr_writedata[15:0];
          3'd3:    seed_q <= csr_writedata;
          default: ;
        endcase
      end
      if (ctrl_wr && !busy) begin
        irq_en_q <= csr_writedata[1];
        verify_q <= csr_writedata[2];
      end
      if (ctrl_wr && csr_writedata[3])
        done_q <= 1'b0;

      if (rd_mismatch) begin
        if (err_cnt_q == '0)
          fail_addr_q <= exp_addr_q;
        if (err_cnt_q != ERR_MAX)
          err_cnt_q <= err_cnt_q + 16'd1;
      end

      case (state_q)
        IDLE: begin
          // START takes priority over a CLR_DONE written in the same word.
          if (start) begin
            err_cnt_q    <= '0;
            fail_addr_q  <= '0;
            start_addr_q <= start_base;
            cur_addr_q   <= start_base;
            cur_data_q   <= seed_q;
            cnt_q        <= len_q - 16'd1;
            if (len_q == '0) begin
              done_q <= 1'b1;
            end else begin
              done_q  <= 1'b0;
              state_q <= FILL;
            end
          end
        end
        FILL: begin
          cur_addr_q <= next_addr;
          cur_data_q <= cur_data_q + 32'd1;
          cnt_q      <= cnt_q - 16'd1;
          if (cnt_q == '0) begin
            if (verify_q) begin
              state_q    <= RDISS;
              cur_addr_q <= start_addr_q;
              cur_data_q <= seed_q;
              cnt_q      <= len_q - 16'd1;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        RDISS: begin
          exp_valid_q <= 1'b1;
          exp_data_q  <= cur_data_q;
          exp_addr_q  <= cur_addr_q;
          cur_addr_q  <= next_addr;
          cur_data_q  <= cur_data_q + 32'd1;
          cnt_q       <= cnt_q - 16'd1;
          if (cnt_q == '0)
            state_q <= RDLAST;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
